add_sub_seq_ctrl: RTL and testbench



---
 rtl/add_sub_seq_ctrl_if.sv | 25 ++
 rtl/ripple_carry_add_and_sub_4bit_d.sv | 25 ++
 rtl/add_sub_seq_ctrl.sv | 103 ++++++++++
 tb/tb_add_sub_seq_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_seq_ctrl_if.sv
// Requester-side handshake and operand bundle for add_sub_seq_ctrl.
// The master drives the request and operands. The slave returns status and the result.
interface add_sub_seq_ctrl_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             start;
    logic             M;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, M, a, b,
        input  busy, done, result, c_out, ovf
    );

    modport slave (
        input  start, M, a, b,
        output busy, done, result, c_out, ovf
    );
endinterface

// File: rtl/ripple_carry_add_and_sub_4bit_d.sv
// 4-bit ripple-carry adder/subtractor slice: sum = a + (b ^ {4{M}}) + c_in.
// When M=1 and c_in=1 the slice computes a - b.
module ripple_carry_add_and_sub_4bit_d (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    input  logic       M,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [3:0] bx;
    logic [4:0] c;

    always_comb begin
        bx   = b ^ {4{M}};
        c    = '0;
        c[0] = c_in;
        sum  = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ bx[i] ^ c[i];
            c[i + 1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
        c_out = c[4];
    end
endmodule

// File: rtl/add_sub_seq_ctrl.sv
// Sequential WIDTH-bit add/subtract controller that time-shares one 4-bit slice,
// processing one nibble per clock, LSB first, with a start/busy/done handshake.
module add_sub_seq_ctrl #(
    parameter int unsigned WIDTH = 16  // multiple of 4, at least 4
) (
    input logic                 clk,
    input logic                 rst_n,
    add_sub_seq_ctrl_if.slave   bus
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state;
    logic [IW-1:0]    idx;
    logic             cy;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_m;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;
    logic             busy;
    logic             done;

    logic [3:0]       sl_a;
    logic [3:0]       sl_b;
    logic [3:0]       sl_sum;
    logic             sl_co;

    always_comb begin
        sl_a = op_a[4*idx +: 4];
        sl_b = op_b[4*idx +: 4];
    end

    ripple_carry_add_and_sub_4bit_d u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .c_in  (cy),
        .M     (op_m),
        .sum   (sl_sum),
        .c_out (sl_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= StIdle;
            idx    <= '0;
            cy     <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            op_m   <= 1'b0;
            result <= '0;
            c_out  <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        op_a   <= bus.a;
                        op_b   <= bus.b;
                        op_m   <= bus.M;
                        idx    <= '0;
                        cy     <= bus.M;  // subtract is a + ~b + 1
                        result <= '0;
                        c_out  <= 1'b0;
                        ovf    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= StRun;
                    end
                end
                StRun: begin
                    result[4*idx +: 4] <= sl_sum;
                    cy                 <= sl_co;
                    idx                <= idx + 1'b1;
                    if (idx == IW'(NIB - 1)) begin
                        c_out <= sl_co;
                        // Same effective operand signs, result sign differs.
                        ovf   <= (op_a[WIDTH-1] == (op_b[WIDTH-1] ^ op_m)) &&
                                 (sl_sum[3] != op_a[WIDTH-1]);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result;
    assign bus.c_out  = c_out;
    assign bus.ovf    = ovf;
endmodule

// File: tb/tb_add_sub_seq_ctrl.sv
// Self-checking bench for add_sub_seq_ctrl: directed vector table, corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_add_sub_seq_ctrl;
    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    add_sub_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    add_sub_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic [15:0] r;
        logic        c;
        logic        v;
        bit          poke;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic m,
                         output logic [15:0] r, output logic c, output logic v);
        int unsigned ua;
        int unsigned ub;
        int sa;
        int sb;
        int sr;
        ua = 32'(a);
        ub = 32'(b);
        sa = 32'($signed(a));
        sb = 32'($signed(b));
        if (m) begin
            r  = 16'(ua - ub);
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = 16'(ua + ub);
            c  = (ua + ub) > 32'd65535;
            sr = sa + sb;
        end
        v = (sr > 32767) || (sr < -32768);
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic m, input logic [15:0] er, input logic ec,
                          input logic ev, input bit poke);
        int  nbusy = 0;
        bit  seen  = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.M = m;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                break;
            end
            if (bus.busy) nbusy++;
            if (poke && k == 1) begin
                bus.start = 1'b1;
                bus.a = 16'hAAAA;
                bus.b = 16'h5555;
                bus.M = 1'b0;
            end else if (poke && k == 2) begin
                bus.start = 1'b0;
            end
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_busy_cycles"}, 32'(nbusy), 32'd4);
        chk({name, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        chk({name, "_result"}, 32'(bus.result), 32'(er));
        chk({name, "_c_out"}, 32'(bus.c_out), 32'(ec));
        chk({name, "_ovf"}, 32'(bus.ovf), 32'(ev));
        @(negedge clk);
        chk({name, "_done_width"}, 32'(bus.done), 32'd0);
        chk({name, "_hold_result"}, 32'(bus.result), 32'(er));
        if (poke) begin
            @(negedge clk);
            chk({name, "_no_queued_op"}, 32'(bus.busy), 32'd0);
        end
    endtask

    vec_t vecs[6];

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rm;
        logic [15:0] er;
        logic        ec;
        logic        ev;
        int          dseen;

        vecs[0] = '{"add_carry_chain", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"add_wrap",        16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"add_ovf",         16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"sub_borrow",      16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"sub_no_borrow",   16'h000D, 16'h0007, 1'b1, 16'h0006, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{"sub_ovf_ignore",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1};

        bus.start = 1'b0;
        bus.M = 1'b0;
        bus.a = '0;
        bus.b = '0;

        // Reset, with start asserted on the last reset edge: reset must win.
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 begin
            rst_n = 1'b1;
            bus.start = 1'b0;
        end
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_result", 32'(bus.result), 32'd0);
        chk("reset_c_out", 32'(bus.c_out), 32'd0);
        chk("reset_ovf", 32'(bus.ovf), 32'd0);

        // Reset asserted at the second RUN edge aborts the operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 16'h1234;
        bus.b = 16'h0FFF;
        bus.M = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_c_out", 32'(bus.c_out), 32'd0);
        chk("abort_ovf", 32'(bus.ovf), 32'd0);
        dseen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dseen++;
        end
        chk("abort_no_done", 32'(dseen), 32'd0);
        run_op("after_abort", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].m,
                   vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].poke);
        end

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rm = 1'($urandom_range(0, 1));
            model(ra, rb, rm, er, ec, ev);
            run_op($sformatf("rand%0d", i), ra, rb, rm, er, ec, ev, 1'b0);
        end

        // Back-to-back with start held high: captures every 6 cycles.
        begin
            logic [15:0] qa[$];
            logic [15:0] qb[$];
            logic        qm[$];
            int          cyc = 0;
            int          last_cap = -1;
            int          ndone = 0;
            logic        prev_busy = 1'b0;
            logic        prev_done = 1'b0;
            @(negedge clk);
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            bus.M = 1'b0;
            bus.start = 1'b1;
            for (int k = 0; k < 60 && ndone < 6; k++) begin
                @(negedge clk);
                cyc++;
                if (bus.done && prev_done) chk("b2b_done_width", 32'd2, 32'd1);
                if (bus.busy && !prev_busy) begin
                    if (last_cap >= 0) chk("b2b_interval", 32'(cyc - last_cap), 32'd6);
                    last_cap = cyc;
                    qa.push_back(bus.a);
                    qb.push_back(bus.b);
                    qm.push_back(bus.M);
                    bus.a = 16'($urandom);
                    bus.b = 16'($urandom);
                    bus.M = ~bus.M;
                end
                if (bus.done) begin
                    ndone++;
                    if (qa.size() == 0) begin
                        chk("b2b_unexpected_done", 32'd1, 32'd0);
                    end else begin
                        model(qa.pop_front(), qb.pop_front(), qm.pop_front(), er, ec, ev);
                        chk("b2b_result", 32'(bus.result), 32'(er));
                        chk("b2b_c_out", 32'(bus.c_out), 32'(ec));
                        chk("b2b_ovf", 32'(bus.ovf), 32'(ev));
                    end
                end
                prev_busy = bus.busy;
                prev_done = bus.done;
            end
            chk("b2b_done_count", 32'(ndone), 32'd6);
            bus.start = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
